// File: rtl/hamming_pair_sequencer.sv
// Min/max Hamming distance over every operand pair (j<k) held in data memory.
// Define HAM_PAIR_IDX_EN to also write the (j,k) indices of the min and max pairs.
module hamming_pair_sequencer #(
    parameter int NUM_OPS   = 32,
    parameter int BASE_ADDR = 0,
    parameter int MIN_ADDR  = 64,
    parameter int MAX_ADDR  = 65
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    output logic [7:0] o_mem_addr,
    input  logic [7:0] i_mem_rdata,
    output logic       o_mem_wen,
    output logic [7:0] o_mem_wdata,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [7:0] LP_BASE   = 8'(BASE_ADDR);
    localparam logic [7:0] LP_MIN    = 8'(MIN_ADDR);
    localparam logic [7:0] LP_MAX    = 8'(MAX_ADDR);
    localparam logic [7:0] LP_LAST_K = 8'(NUM_OPS - 1);
    localparam logic [7:0] LP_LAST_J = 8'(NUM_OPS - 2);
    localparam bit         LP_NO_PAIRS = (NUM_OPS < 2);

    if (BASE_ADDR + 2 * NUM_OPS > 256) begin : g_cfg_check
        $error("hamming_pair_sequencer: operand table overruns the 8-bit address space");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_RD_AH, S_RD_AL, S_CAP_A, S_RD_BH, S_RD_BL, S_CAP_B, S_CMP,
        S_WR_MIN, S_WR_MAX,
`ifdef HAM_PAIR_IDX_EN
        S_WR_I0, S_WR_I1, S_WR_I2, S_WR_I3,
`endif
        S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_j, r_k, r_hi;
    logic [15:0] r_a, r_b;
    logic [4:0]  r_min, r_max;
    logic [4:0]  w_dist;
    logic [15:0] w_x;
    logic        w_go;
`ifdef HAM_PAIR_IDX_EN
    logic [7:0]  r_min_j, r_min_k, r_max_j, r_max_k;
`endif

    assign w_go = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_x  = r_a ^ r_b;

    always_comb begin
        w_dist = '0;
        for (int i = 0; i < 16; i++) w_dist = w_dist + 5'(w_x[i]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_mem_addr  = '0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_next = LP_NO_PAIRS ? S_WR_MIN : S_RD_AH;
            S_RD_AH: begin o_mem_addr = LP_BASE + {r_j[6:0], 1'b0};         w_next = S_RD_AL; end
            S_RD_AL: begin o_mem_addr = LP_BASE + {r_j[6:0], 1'b0} + 8'd1;  w_next = S_CAP_A; end
            S_CAP_A: w_next = S_RD_BH;
            S_RD_BH: begin o_mem_addr = LP_BASE + {r_k[6:0], 1'b0};         w_next = S_RD_BL; end
            S_RD_BL: begin o_mem_addr = LP_BASE + {r_k[6:0], 1'b0} + 8'd1;  w_next = S_CAP_B; end
            S_CAP_B: w_next = S_CMP;
            S_CMP: begin
                if (r_k < LP_LAST_K)      w_next = S_RD_BH;
                else if (r_j < LP_LAST_J) w_next = S_RD_AH;
                else                      w_next = S_WR_MIN;
            end
            S_WR_MIN: begin
                o_mem_addr = LP_MIN; o_mem_wen = 1'b1; o_mem_wdata = {3'b0, r_min};
                w_next = S_WR_MAX;
            end
            S_WR_MAX: begin
                o_mem_addr = LP_MAX; o_mem_wen = 1'b1; o_mem_wdata = {3'b0, r_max};
`ifdef HAM_PAIR_IDX_EN
                w_next = S_WR_I0;
`else
                w_next = S_DONE;
`endif
            end
`ifdef HAM_PAIR_IDX_EN
            S_WR_I0: begin o_mem_addr = LP_MAX + 8'd1; o_mem_wen = 1'b1; o_mem_wdata = r_min_j; w_next = S_WR_I1; end
            S_WR_I1: begin o_mem_addr = LP_MAX + 8'd2; o_mem_wen = 1'b1; o_mem_wdata = r_min_k; w_next = S_WR_I2; end
            S_WR_I2: begin o_mem_addr = LP_MAX + 8'd3; o_mem_wen = 1'b1; o_mem_wdata = r_max_j; w_next = S_WR_I3; end
            S_WR_I3: begin o_mem_addr = LP_MAX + 8'd4; o_mem_wen = 1'b1; o_mem_wdata = r_max_k; w_next = S_DONE;  end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign o_busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done = (r_state == S_DONE);

    // Strict compares keep the first pair in (j,k) order on ties.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_go) begin
            r_j   <= 8'd0;
            r_k   <= 8'd1;
            r_min <= 5'd16;
            r_max <= 5'd0;
            r_hi  <= 8'd0;
            r_a   <= 16'd0;
            r_b   <= 16'd0;
`ifdef HAM_PAIR_IDX_EN
            r_min_j <= 8'd0; r_min_k <= 8'd0; r_max_j <= 8'd0; r_max_k <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_RD_AL, S_RD_BL: r_hi <= i_mem_rdata;
                S_CAP_A: r_a <= {r_hi, i_mem_rdata};
                S_CAP_B: r_b <= {r_hi, i_mem_rdata};
                S_CMP: begin
                    if (w_dist < r_min) begin
                        r_min <= w_dist;
`ifdef HAM_PAIR_IDX_EN
                        r_min_j <= r_j; r_min_k <= r_k;
`endif
                    end
                    if (w_dist > r_max) begin
                        r_max <= w_dist;
`ifdef HAM_PAIR_IDX_EN
                        r_max_j <= r_j; r_max_k <= r_k;
`endif
                    end
                    if (r_k < LP_LAST_K) begin
                        r_k <= r_k + 8'd1;
                    end else if (r_j < LP_LAST_J) begin
                        r_j <= r_j + 8'd1;
                        r_k <= r_j + 8'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_pair_sequencer.sv
// Directed bench for hamming_pair_sequencer: table of operand patterns plus
// reset/start corner sequences and a NUM_OPS=1 instance.
module tb_hamming_pair_sequencer;

`ifdef HAM_PAIR_IDX_EN
    localparam int LAT = 2084, LAT1 = 7, NWR = 6;
`else
    localparam int LAT = 2080, LAT1 = 3, NWR = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, start1;
    logic [7:0] addr, rdata, wdata, addr1, wdata1;
    logic       wen, busy, done, wen1, busy1, done1;
    logic [7:0] mem [0:255];
    logic [7:0] exp_img [0:255];
    logic       ld_en;
    logic [7:0] ld_a, ld_d;
    int         n_wr = 0, n1_wr = 0;
    logic [7:0] w1_min = 8'hEE, w1_max = 8'hEE;
    int         n_cmp = 0, n_err = 0;
    logic [15:0] op_buf [32];

    typedef struct {
        logic [15:0] v0, vrest, vlast;
        logic [7:0]  mn, mx, mnj, mnk, mxj, mxk;
    } vec_t;
    vec_t vecs [5];

    hamming_pair_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .o_mem_addr(addr),
        .i_mem_rdata(rdata), .o_mem_wen(wen), .o_mem_wdata(wdata),
        .o_busy(busy), .o_done(done)
    );

    hamming_pair_sequencer #(.NUM_OPS(1)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_start(start1), .o_mem_addr(addr1),
        .i_mem_rdata(8'h00), .o_mem_wen(wen1), .o_mem_wdata(wdata1),
        .o_busy(busy1), .o_done(done1)
    );

    always @(posedge clk) begin
        rdata <= mem[addr];
        if (wen) begin
            mem[addr] <= wdata;
            n_wr <= n_wr + 1;
        end
        if (ld_en) mem[ld_a] <= ld_d;
        if (wen1) begin
            n1_wr <= n1_wr + 1;
            if (addr1 == 8'd64) w1_min <= wdata1;
            if (addr1 == 8'd65) w1_max <= wdata1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic load_mem();
        for (int a = 0; a < 256; a++) begin
            if (a < 64) exp_img[a] = a[0] ? op_buf[a/2][7:0] : op_buf[a/2][15:8];
            else        exp_img[a] = 8'(a) ^ 8'hA5;
            ld_a = 8'(a); ld_d = exp_img[a]; ld_en = 1'b1;
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    // Pulses start (cycle 0), optionally re-pulses it at cycles 5 and 500, waits for done.
    task automatic do_run(input string nm, input bit glitch, output int cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk({nm, ".busy_c1"}, 32'(busy), 1);
        chk({nm, ".done_c1"}, 32'(done), 0);
        while (!done && cyc < 3000) begin
            start = glitch && (cyc == 5 || cyc == 500);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({nm, ".done"}, 32'(done), 1);
        chk({nm, ".latency"}, cyc, LAT);
    endtask

    task automatic check_results(input string nm, input vec_t v, input int wr0);
        int bad;
        bad = 0;
        chk({nm, ".min"}, 32'(mem[64]), 32'(v.mn));
        chk({nm, ".max"}, 32'(mem[65]), 32'(v.mx));
        exp_img[64] = v.mn;
        exp_img[65] = v.mx;
`ifdef HAM_PAIR_IDX_EN
        chk({nm, ".min_j"}, 32'(mem[66]), 32'(v.mnj));
        chk({nm, ".min_k"}, 32'(mem[67]), 32'(v.mnk));
        chk({nm, ".max_j"}, 32'(mem[68]), 32'(v.mxj));
        chk({nm, ".max_k"}, 32'(mem[69]), 32'(v.mxk));
        exp_img[66] = v.mnj; exp_img[67] = v.mnk; exp_img[68] = v.mxj; exp_img[69] = v.mxk;
`endif
        for (int a = 0; a < 256; a++) if (mem[a] !== exp_img[a]) bad++;
        chk({nm, ".untouched"}, bad, 0);
        chk({nm, ".nwrites"}, n_wr - wr0, NWR);
    endtask

    function automatic vec_t golden();
        vec_t g;
        int   d;
        g = vecs[0];
        g.mn = 8'd16; g.mx = 8'd0;
        g.mnj = 0; g.mnk = 0; g.mxj = 0; g.mxk = 0;
        for (int j = 0; j < 32; j++)
            for (int k = j + 1; k < 32; k++) begin
                d = $countones(op_buf[j] ^ op_buf[k]);
                if (d < int'(g.mn)) begin g.mn = 8'(d); g.mnj = 8'(j); g.mnk = 8'(k); end
                if (d > int'(g.mx)) begin g.mx = 8'(d); g.mxj = 8'(j); g.mxk = 8'(k); end
            end
        return g;
    endfunction

    task automatic fill_ops(input vec_t v);
        for (int i = 0; i < 32; i++)
            op_buf[i] = (i == 0) ? v.v0 : (i == 31) ? v.vlast : v.vrest;
    endtask

    initial begin
        int   cyc, wr0;
        vec_t g;
        reset = 1'b1; start = 1'b0; start1 = 1'b0;
        ld_en = 1'b0; ld_a = '0; ld_d = '0;

        //             v0        vrest     vlast     mn  mx  mnj mnk mxj mxk
        vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 0,  0,  0,  1,  0,  0};
        vecs[1] = '{16'hFFFF, 16'h0000, 16'h0000, 0,  16, 1,  2,  0,  1};
        vecs[2] = '{16'hAAAA, 16'hAAAA, 16'h5555, 0,  16, 0,  1,  0,  31};
        vecs[3] = '{16'h0001, 16'h0000, 16'h0003, 0,  2,  1,  2,  1,  31};
        vecs[4] = '{16'h8000, 16'h00FF, 16'hFF00, 0,  16, 1,  2,  1,  31};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.addr", 32'(addr), 0);
        chk("rst.wen", 32'(wen), 0);
        chk("rst.wdata", 32'(wdata), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.done1", 32'(done1), 0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        chk("rst_beats_start.busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            fill_ops(vecs[i]);
            load_mem();
            wr0 = n_wr;
            do_run($sformatf("vec%0d", i), 1'b0, cyc);
            check_results($sformatf("vec%0d", i), vecs[i], wr0);
        end

        for (int i = 0; i < 32; i++) op_buf[i] = 16'($urandom);
        load_mem();
        g = golden();
        wr0 = n_wr;
        do_run("rand", 1'b0, cyc);
        check_results("rand", g, wr0);

        // Abort mid-run at cycle 1000, then rerun on the same data.
        load_mem();
        wr0 = n_wr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 1000) begin @(posedge clk); #1; cyc++; end
        chk("abort.busy_before", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(done), 0);
        chk("abort.wen", 32'(wen), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort.done_later", 32'(done), 0);
        chk("abort.nwrites", n_wr - wr0, 0);
        chk("abort.min_untouched", 32'(mem[64]), 32'(exp_img[64]));
        wr0 = n_wr;
        do_run("rerun", 1'b0, cyc);
        check_results("rerun", g, wr0);

        // Start pulses while busy are ignored; start in DONE reruns.
        fill_ops(vecs[3]);
        load_mem();
        wr0 = n_wr;
        do_run("glitch", 1'b1, cyc);
        check_results("glitch", vecs[3], wr0);
        wr0 = n_wr;
        do_run("from_done", 1'b0, cyc);
        check_results("from_done", vecs[3], wr0);

        // NUM_OPS=1 instance: no pairs, defaults written.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 1;
        chk("n1.busy_c1", 32'(busy1), 1);
        while (!done1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("n1.latency", cyc, LAT1);
        chk("n1.min", 32'(w1_min), 16);
        chk("n1.max", 32'(w1_max), 0);
        chk("n1.nwrites", n1_wr, NWR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
